freq_preset_sequencer: RTL and testbench

FREQ_PRESET_SEQUENCER -- requirements
Module: freq_preset_sequencer

---
 rtl/freq_preset_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_freq_preset_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_preset_sequencer.sv
// Frequency preset sequencer: debounced buttons step or clear an NCO tuning word, then handshake it downstream.
// Latency: a debounced button edge loads FreqData and raises NewDataReady on the following clock edge.
// Backpressure: NewDataReady holds until FreqAck or ACK_TIMEOUT cycles (then load_err); optional AUTO_SWEEP_EN adds timed stepping.
module freq_preset_sequencer #(
`ifdef AUTO_SWEEP_EN
  parameter int          DWELL_CYCLES = 100000000,
`endif
  parameter int          DB_CYCLES    = 1000000,
  parameter int          ACK_TIMEOUT  = 256,
  parameter logic [43:0] PRESET0      = 44'hE12EAA86301,
  parameter logic [43:0] PRESET1      = 44'hCC4EEB76301,
  parameter logic [43:0] PRESET2      = 44'h80000000000,
  parameter logic [43:0] PRESET3      = 44'h40000000000
) (
  input  logic        sysclk,
  input  logic        rst_n,
`ifdef AUTO_SWEEP_EN
  input  logic        sweep_en,
`endif
  input  logic        btn0,
  input  logic        btn1,
  input  logic        FreqAck,
  output logic [43:0] FreqData,
  output logic        NewDataReady,
  output logic [1:0]  preset_idx,
  output logic        busy,
  output logic        load_err
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TOW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  // Button index 0 is "next preset", index 1 is "clear/mute".
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q;
  logic [1:0]     sync2_q;
  logic [1:0]     db_q;
  logic [1:0]     db_prev_q;
  logic [DBW-1:0] db_cnt_q [2];
  logic [1:0]     rise;

  state_t         state_q, state_d;
  logic [43:0]    freq_q, freq_d;
  logic [1:0]     idx_q, idx_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           err_q, err_d;
  logic           step_req;
  logic [1:0]     nxt_idx;

  assign btn_raw = {btn1, btn0};

  // Two-flop synchronizer then debounce: state flips only after DB_CYCLES
  // consecutive samples that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  // One-cycle pulse on each debounced rising edge.
  assign rise = db_q & ~db_prev_q;

`ifdef AUTO_SWEEP_EN
  localparam int DWW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DWW-1:0] DW_LAST = DWW'(DWELL_CYCLES - 1);

  logic [DWW-1:0] dwell_q;
  logic           sweep_step;

  assign sweep_step = sweep_en && (state_q == IDLE) && (dwell_q == DW_LAST);

  // Dwell timer: counts IDLE cycles while sweeping; button loads and each auto step restart it.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else if (!sweep_en || ((state_q == IDLE) && (|rise)) || sweep_step) begin
      dwell_q <= '0;
    end else if (state_q == IDLE) begin
      dwell_q <= dwell_q + DWW'(1);
    end
  end

  assign step_req = rise[0] | sweep_step;
`else
  assign step_req = rise[0];
`endif

  function automatic logic [43:0] preset_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return PRESET0;
      2'd1:    return PRESET1;
      2'd2:    return PRESET2;
      default: return PRESET3;
    endcase
  endfunction

  assign nxt_idx = idx_q + 2'd1;

  // FSM and datapath registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      freq_q   <= '0;
      idx_q    <= 2'd3;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic. Clear beats step in IDLE; in LOAD a clear restarts the
  // load (the ack, if any, referred to the word being replaced), otherwise ack
  // beats timeout so a last-cycle ack is never reported as an error.
  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (rise[1]) begin
          idx_d    = 2'd3;
          freq_d   = '0;
          to_cnt_d = '0;
          state_d  = LOAD;
        end else if (step_req) begin
          idx_d    = nxt_idx;
          freq_d   = preset_word(nxt_idx);
          to_cnt_d = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (rise[1]) begin
          idx_d    = 2'd3;
          freq_d   = '0;
          to_cnt_d = '0;
        end else if (FreqAck) begin
          err_d    = 1'b0;
          state_d  = IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign FreqData     = freq_q;
  assign preset_idx   = idx_q;
  assign NewDataReady = (state_q == LOAD);
  assign busy         = (state_q == LOAD);
  assign load_err     = err_q;

endmodule

// File: tb/tb_freq_preset_sequencer.sv
// Directed bench for freq_preset_sequencer with DB_CYCLES=4, ACK_TIMEOUT=8.
// Inputs driven and outputs sampled on the falling clock edge.
// Acknowledge timing is controlled explicitly per step.
module tb_freq_preset_sequencer;

  localparam logic [43:0] P0 = 44'hE12EAA86301;
  localparam logic [43:0] P1 = 44'hCC4EEB76301;
  localparam logic [43:0] P2 = 44'h80000000000;
  localparam logic [43:0] P3 = 44'h40000000000;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        btn0   = 1'b0;
  logic        btn1   = 1'b0;
  logic        FreqAck = 1'b0;
  logic [43:0] FreqData;
  logic        NewDataReady;
  logic [1:0]  preset_idx;
  logic        busy;
  logic        load_err;

  int n_cmp = 0;
  int n_mis = 0;

  freq_preset_sequencer #(
    .DB_CYCLES  (4),
    .ACK_TIMEOUT(8)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .btn0        (btn0),
    .btn1        (btn1),
    .FreqAck     (FreqAck),
    .FreqData    (FreqData),
    .NewDataReady(NewDataReady),
    .preset_idx  (preset_idx),
    .busy        (busy),
    .load_err    (load_err)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic wait_ndr(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (NewDataReady) begin
        seen = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  // Press button(s) for 8 cycles, expect a load, optionally ack it, then let the release settle.
  task automatic step(input string tag, input bit b0, input bit b1, input bit do_ack,
                      input logic [1:0] exp_idx, input logic [43:0] exp_freq);
    bit seen;
    btn0 = b0;
    btn1 = b1;
    cyc(8);
    btn0 = 1'b0;
    btn1 = 1'b0;
    wait_ndr(20, seen);
    check({tag, "_ndr"}, 64'(seen), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_idx"}, 64'(preset_idx), 64'(exp_idx));
    check({tag, "_freq"}, 64'(FreqData), 64'(exp_freq));
    if (do_ack) begin
      FreqAck = 1'b1;
      cyc(1);
      FreqAck = 1'b0;
      check({tag, "_ndr_drop"}, 64'(NewDataReady), 64'd0);
      check({tag, "_err"}, 64'(load_err), 64'd0);
    end
    cyc(12);
  endtask

  initial begin
    bit seen;
    int hi;

    // Reset values
    cyc(2);
    check("rst_idx", 64'(preset_idx), 64'd3);
    check("rst_freq", 64'(FreqData), 64'd0);
    check("rst_ndr", 64'(NewDataReady), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(load_err), 64'd0);
    rst_n = 1'b1;
    cyc(2);

    // First press: NDR rises 7 cycles after press, ack 2 cycles later, high 3 cycles
    btn0 = 1'b1;
    cyc(6);
    check("p0_ndr_early", 64'(NewDataReady), 64'd0);
    cyc(1);
    check("p0_ndr_rise", 64'(NewDataReady), 64'd1);
    check("p0_idx", 64'(preset_idx), 64'd0);
    check("p0_freq", 64'(FreqData), 64'(P0));
    cyc(2);
    check("p0_ndr_hold", 64'(NewDataReady), 64'd1);
    FreqAck = 1'b1;
    cyc(1);
    FreqAck = 1'b0;
    btn0 = 1'b0;
    check("p0_ndr_fall", 64'(NewDataReady), 64'd0);
    check("p0_idx_after", 64'(preset_idx), 64'd0);
    check("p0_freq_after", 64'(FreqData), 64'(P0));
    cyc(10);

    // Four more steps, wrapping 3 -> 0
    step("s1", 1'b1, 1'b0, 1'b1, 2'd1, P1);
    step("s2", 1'b1, 1'b0, 1'b1, 2'd2, P2);
    step("s3", 1'b1, 1'b0, 1'b1, 2'd3, P3);
    step("s4", 1'b1, 1'b0, 1'b1, 2'd0, P0);

    // Three-cycle glitch is filtered
    btn0 = 1'b1;
    cyc(3);
    btn0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (NewDataReady) seen = 1'b1;
      cyc(1);
    end
    check("glitch_ndr", 64'(seen), 64'd0);
    check("glitch_idx", 64'(preset_idx), 64'd0);

    // Ack in IDLE has no effect
    FreqAck = 1'b1;
    cyc(3);
    check("idle_ack_ndr", 64'(NewDataReady), 64'd0);
    check("idle_ack_freq", 64'(FreqData), 64'(P0));
    FreqAck = 1'b0;
    cyc(2);

    // Unacked load times out after exactly 8 LOAD cycles
    btn0 = 1'b1;
    cyc(7);
    btn0 = 1'b0;
    check("to_ndr_rise", 64'(NewDataReady), 64'd1);
    hi = 0;
    while (NewDataReady && hi < 40) begin
      hi++;
      cyc(1);
    end
    check("to_len", 64'(hi), 64'd8);
    check("to_err", 64'(load_err), 64'd1);
    check("to_idx", 64'(preset_idx), 64'd1);
    check("to_freq", 64'(FreqData), 64'(P1));
    cyc(6);
    step("to_next", 1'b1, 1'b0, 1'b1, 2'd2, P2);

    // btn0 edge arriving during a btn1 load is dropped
    btn1 = 1'b1;
    cyc(1);
    btn0 = 1'b1;
    cyc(7);
    check("drop_ndr", 64'(NewDataReady), 64'd1);
    cyc(2);
    btn0 = 1'b0;
    btn1 = 1'b0;
    check("drop_idx", 64'(preset_idx), 64'd3);
    check("drop_freq", 64'(FreqData), 64'd0);
    FreqAck = 1'b1;
    cyc(1);
    FreqAck = 1'b0;
    check("drop_ndr_fall", 64'(NewDataReady), 64'd0);
    cyc(12);
    check("drop_idx_after", 64'(preset_idx), 64'd3);

    // btn1 during a btn0 load clears the word and restarts the timeout (8 + 3 = 11 cycles high)
    btn0 = 1'b1;
    cyc(3);
    btn1 = 1'b1;
    cyc(4);
    btn0 = 1'b0;
    check("clr_ndr", 64'(NewDataReady), 64'd1);
    check("clr_freq_pre", 64'(FreqData), 64'(P0));
    cyc(2);
    check("clr_freq_hold", 64'(FreqData), 64'(P0));
    cyc(1);
    btn1 = 1'b0;
    check("clr_freq", 64'(FreqData), 64'd0);
    check("clr_idx", 64'(preset_idx), 64'd3);
    hi = 3;
    while (NewDataReady && hi < 40) begin
      hi++;
      cyc(1);
    end
    check("clr_len", 64'(hi), 64'd11);
    check("clr_err", 64'(load_err), 64'd1);
    cyc(12);

    // Reset mid-LOAD aborts immediately; held button re-triggers after release
    btn0 = 1'b1;
    cyc(8);
    check("rl_ndr", 64'(NewDataReady), 64'd1);
    check("rl_err_pre", 64'(load_err), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rl_ndr_rst", 64'(NewDataReady), 64'd0);
    check("rl_busy_rst", 64'(busy), 64'd0);
    check("rl_idx_rst", 64'(preset_idx), 64'd3);
    check("rl_freq_rst", 64'(FreqData), 64'd0);
    check("rl_err_rst", 64'(load_err), 64'd0);
    cyc(1);
    rst_n = 1'b1;
    wait_ndr(30, seen);
    check("rl_reedge", 64'(seen), 64'd1);
    check("rl_idx", 64'(preset_idx), 64'd0);
    check("rl_freq", 64'(FreqData), 64'(P0));
    btn0 = 1'b0;
    FreqAck = 1'b1;
    cyc(1);
    FreqAck = 1'b0;
    check("rl_ndr_fall", 64'(NewDataReady), 64'd0);
    cyc(12);

    // Simultaneous edges: btn1 wins
    step("both", 1'b1, 1'b1, 1'b1, 2'd3, 44'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
